// File: rtl/rts_step_scheduler_pkg.sv
// Shared types, widths and defaults for the real-time step scheduler.
package rts_step_scheduler_pkg;

  localparam int unsigned PeriodW    = 16;
  localparam int unsigned IterW      = 6;
  localparam int unsigned GapCycDef  = 2;
  localparam int unsigned TimeoutDef = 64;
  localparam int unsigned MinPeriod  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StGap,
    StHold
  } state_e;

  // Terminal count of the period counter after clamping short periods.
  function automatic logic [PeriodW-1:0] period_last(input logic [PeriodW-1:0] p);
    logic [PeriodW-1:0] pc;
    pc = (p < PeriodW'(MinPeriod)) ? PeriodW'(MinPeriod) : p;
    return pc - PeriodW'(1);
  endfunction

endpackage

// File: rtl/rts_step_scheduler_if.sv
// Host/pipeline signal bundle of the step scheduler.
interface rts_step_scheduler_if;
  import rts_step_scheduler_pkg::*;

  logic               run_en;
  logic [PeriodW-1:0] period;
  logic [IterW-1:0]   n_iter;
  logic               pipe_done;
  logic               clr_err;
  logic               sta;
  logic [IterW-1:0]   iter_idx;
  logic               step_tick;
  logic               busy;
  logic               overrun;
  logic               timeout_err;
  logic [31:0]        step_cnt;

  modport master (
    input  run_en, period, n_iter, pipe_done, clr_err,
    output sta, iter_idx, step_tick, busy, overrun, timeout_err, step_cnt
  );

  modport slave (
    output run_en, period, n_iter, pipe_done, clr_err,
    input  sta, iter_idx, step_tick, busy, overrun, timeout_err, step_cnt
  );

endinterface

// File: rtl/rts_period_timer.sv
// Free-running step period counter; period is latched (and clamped) on load.
module rts_period_timer
  import rts_step_scheduler_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic               load_i,
  input  logic [PeriodW-1:0] period_i,
  output logic               tick_o
);

  logic [PeriodW-1:0] cnt_q, cnt_d;
  logic [PeriodW-1:0] last_q, last_d;

  assign tick_o = enable_i && (cnt_q == last_q);

  always_comb begin
    last_d = load_i ? period_last(period_i) : last_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + PeriodW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rts_step_scheduler.sv
// Sequences N solver iterations per fixed-period step and flags overruns and lost completions.
module rts_step_scheduler
  import rts_step_scheduler_pkg::*;
#(
  parameter int unsigned GapCyc  = GapCycDef,
  parameter int unsigned Timeout = TimeoutDef
) (
  input logic                 clk,
  input logic                 rst,
  rts_step_scheduler_if.master bus
);

  localparam int unsigned GapW = (GapCyc > 1) ? $clog2(GapCyc) : 1;
  localparam int unsigned ToW  = $clog2(Timeout);

  state_e            state_q, state_d;
  logic [IterW-1:0]  iter_q, iter_d;
  logic [IterW-1:0]  n_iter_q, n_iter_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [ToW-1:0]    to_q, to_d;
  logic [31:0]       step_cnt_q, step_cnt_d;
  logic              sta_q, sta_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic              tick, load, ovr_set, to_set;
  logic [IterW:0]    iter_next, last;

  assign last      = (n_iter_q == '0) ? (IterW+1)'(1) : {1'b0, n_iter_q};
  assign iter_next = {1'b0, iter_q} + (IterW+1)'(1);

  rts_period_timer u_timer (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clear_i  (state_q == StIdle),
    .enable_i (state_q != StIdle),
    .load_i   (load),
    .period_i (bus.period),
    .tick_o   (tick)
  );

  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    n_iter_d   = n_iter_q;
    gap_d      = gap_q;
    to_d       = to_q;
    step_cnt_d = step_cnt_q;
    load       = 1'b0;
    to_set     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.run_en) begin
          load     = 1'b1;
          n_iter_d = bus.n_iter;
          iter_d   = '0;
          state_d  = StLaunch;
        end
      end
      StLaunch: begin
        // Timeout window counts from the launch clock.
        to_d    = ToW'(1);
        state_d = StWait;
      end
      StWait: begin
        if (bus.pipe_done) begin
          if (iter_next == last) begin
            step_cnt_d = step_cnt_q + 32'd1;
            state_d    = StHold;
          end else begin
            iter_d  = iter_next[IterW-1:0];
            gap_d   = '0;
            state_d = (GapCyc == 0) ? StLaunch : StGap;
          end
        end else if (to_q == ToW'(Timeout - 1)) begin
          to_set  = 1'b1;
          state_d = StHold;
        end else begin
          to_d = to_q + ToW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapW'(GapCyc - 1)) begin
          state_d = StLaunch;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StHold: begin
        if (tick) begin
          if (bus.run_en) begin
            load     = 1'b1;
            n_iter_d = bus.n_iter;
            iter_d   = '0;
            state_d  = StLaunch;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    ovr_set   = tick && (state_q inside {StLaunch, StWait, StGap});
    overrun_d = ovr_set | (overrun_q & ~bus.clr_err);
    timeout_d = to_set | (timeout_q & ~bus.clr_err);
    sta_d     = (state_d == StLaunch);
    busy_d    = (state_d inside {StLaunch, StWait, StGap});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      iter_q     <= '0;
      n_iter_q   <= '0;
      gap_q      <= '0;
      to_q       <= '0;
      step_cnt_q <= '0;
      sta_q      <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      n_iter_q   <= n_iter_d;
      gap_q      <= gap_d;
      to_q       <= to_d;
      step_cnt_q <= step_cnt_d;
      sta_q      <= sta_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.sta         = sta_q;
  assign bus.iter_idx    = iter_q;
  assign bus.step_tick   = tick;
  assign bus.busy        = busy_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_q;
  assign bus.step_cnt    = step_cnt_q;

endmodule
